norm_round_pack: RTL and testbench

- Post-add/sub back end of the single-precision FP adder.
- Takes the raw 25-bit significand sum (carry bit, hidden bit, 23 fraction bits) plus guard/round/sticky bits, exponent and sign.
- Counts leading zeros, normalises (right 1 on carry, left by the leading-zero count otherwise), adjusts the exponent, rounds to nearest-even and packs an IEEE-754 word.
- Two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp32_pkg.sv | 26 ++
 rtl/lzc25.sv | 42 ++++
 rtl/norm_round_pack.sv | 251 +++++++++++++++++++++++++
 tb/tb_norm_round_pack.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision constants and field layout for the FP
// adder back end.
//   EXP_W / FRAC_W : exponent and fraction widths of an IEEE-754 single
//   BIAS / EXP_MAX : exponent bias and the all-ones (inf/NaN) exponent code
//   LZC_W          : width of the leading-zero counter input
//   QNAN/INF/ZERO  : canonical packed encodings (sign bit clear)
//   fp32_t         : packed {sign, exp, frac} view of a 32-bit word
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int LZC_W   = FRAC_W + 2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp;
    logic [FRAC_W-1:0]  frac;
  } fp32_t;

endpackage

// File: rtl/lzc25.sv
// lzc25: combinational 25-bit leading-zero counter.
//   vec_i      : vector to scan, MSB first
//   count_o    : number of zeros above the most significant one (0..24);
//                reads 25 when the vector is all zero
//   all_zero_o : vec_i has no bit set
module lzc25
  import fp32_pkg::*;
(
  input  logic [LZC_W-1:0] vec_i,
  output logic [4:0]       count_o,
  output logic             all_zero_o
);

  // One-hot marker of the most significant set bit.
  logic [LZC_W-1:0] first_one;

  genvar gi;
  generate
    for (gi = 0; gi < LZC_W; gi++) begin : g_first
      if (gi == LZC_W - 1) begin : g_top
        assign first_one[gi] = vec_i[gi];
      end else begin : g_low
        assign first_one[gi] = vec_i[gi] & ~|vec_i[LZC_W-1:gi+1];
      end
    end
  endgenerate

  // first_one is one-hot, so OR-ing the encodings of its set bit is exact.
  always_comb begin
    count_o    = '0;
    all_zero_o = ~|vec_i;
    for (int i = 0; i < LZC_W; i++) begin
      if (first_one[i]) begin
        count_o = count_o | 5'(LZC_W - 1 - i);
      end
    end
    if (all_zero_o) begin
      count_o = 5'(LZC_W);
    end
  end

endmodule

// File: rtl/norm_round_pack.sv
// norm_round_pack: normalise / round-to-nearest-even / pack back end of the
// single-precision adder. Two register stages plus a registered output,
// all advancing together whenever the output is free or being consumed.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = pipe may advance)
//   sig_in              : raw sum {carry, hidden, fraction}
//   grs_in              : guard, round, sticky bits below sig_in[0]
//   exp_in, sign_in     : biased exponent of the larger operand, result sign
//   out_valid/out_ready : output handshake; outputs hold while stalled
//   out_data            : packed IEEE-754 result
//   out_ovf/unf/zero    : overflow to inf, flush to zero, exact zero
module norm_round_pack
  import fp32_pkg::fp32_t;
  import fp32_pkg::EXP_MAX;
  import fp32_pkg::INF;
  import fp32_pkg::ZERO;
#(
  parameter int EXP_W  = 8,   // only 8 is supported
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W+1:0] sig_in,
  input  logic [2:0]        grs_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_zero
);

  localparam int SIG_W = FRAC_W + 2;   // carry + hidden + fraction
  localparam int M_W   = FRAC_W + 1;   // normalised significand
  localparam int N_W   = M_W + 3;      // significand plus G, R, S
  localparam int E_W   = EXP_W + 2;    // signed exponent with headroom

  localparam logic signed [E_W-1:0] E_ONE   = {{(E_W-1){1'b0}}, 1'b1};
  localparam logic signed [E_W-1:0] E_ZERO  = '0;
  localparam logic signed [E_W-1:0] E_MAX_S = EXP_MAX[E_W-1:0];

  logic adv;

  // ---------------- stage 1: input capture + leading-zero count ---------
  logic             s1_valid_q, s1_valid_d;
  logic [SIG_W-1:0] s1_sig_q,   s1_sig_d;
  logic [2:0]       s1_grs_q,   s1_grs_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [4:0]       s1_lz_q,    s1_lz_d;
  logic             s1_zero_q,  s1_zero_d;

  logic [4:0] lzc_count;
  logic       lzc_all_zero;

  // A zero is appended so the counter scans sig[23:0] only; an all-zero
  // scan then means the whole hidden+fraction field is empty.
  lzc25 u_lzc (
    .vec_i      ({sig_in[M_W-1:0], 1'b0}),
    .count_o    (lzc_count),
    .all_zero_o (lzc_all_zero)
  );

  // ---------------- stage 2: normalised significand + exponent ----------
  logic                  s2_valid_q, s2_valid_d;
  logic [N_W-1:0]        s2_n_q,     s2_n_d;
  logic signed [E_W-1:0] s2_e_q,     s2_e_d;
  logic                  s2_zero_q,  s2_zero_d;
  logic                  s2_sign_q,  s2_sign_d;

  logic [N_W-1:0]        norm_n;
  logic signed [E_W-1:0] norm_e;

  // ---------------- output stage ----------------------------------------
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_ovf_q,   out_ovf_d;
  logic        out_unf_q,   out_unf_d;
  logic        out_zero_q,  out_zero_d;

  logic [M_W-1:0]        m;
  logic                  g_bit, r_bit, s_bit, round_up;
  logic [M_W:0]          m_sum;
  logic [FRAC_W-1:0]     frac_rnd;
  logic signed [E_W-1:0] e_rnd;
  logic                  unused_hidden;
  fp32_t                 res;
  logic                  res_ovf, res_unf, res_zero;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sig_d   = s1_sig_q;
    s1_grs_d   = s1_grs_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_lz_d    = s1_lz_q;
    s1_zero_d  = s1_zero_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_sig_d   = sig_in;
      s1_grs_d   = grs_in;
      s1_exp_d   = exp_in;
      s1_sign_d  = sign_in;
      s1_lz_d    = lzc_all_zero ? 5'd24 : lzc_count;
      s1_zero_d  = lzc_all_zero & ~sig_in[SIG_W-1] & ~|grs_in;
    end
  end

  // Normalisation. The hidden-bit-set case is the lz=0 instance of the
  // left-shift path, so it needs no branch of its own.
  always_comb begin
    if (s1_sig_q[SIG_W-1]) begin
      norm_n = {s1_sig_q, s1_grs_q[2], |s1_grs_q[1:0]};
      norm_e = $signed({2'b00, s1_exp_q}) + E_ONE;
    end else begin
      norm_n = {s1_sig_q[M_W-1:0], s1_grs_q} << s1_lz_q;
      norm_e = $signed({2'b00, s1_exp_q}) - $signed({{(E_W-5){1'b0}}, s1_lz_q});
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_n_d     = s2_n_q;
    s2_e_d     = s2_e_q;
    s2_zero_d  = s2_zero_q;
    s2_sign_d  = s2_sign_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_n_d     = norm_n;
      s2_e_d     = norm_e;
      s2_zero_d  = s1_zero_q;
      s2_sign_d  = s1_sign_q;
    end
  end

  // Round to nearest, ties to even.
  assign m        = s2_n_q[N_W-1:3];
  assign g_bit    = s2_n_q[2];
  assign r_bit    = s2_n_q[1];
  assign s_bit    = s2_n_q[0];
  assign round_up = g_bit & (r_bit | s_bit | m[0]);
  assign m_sum    = {1'b0, m} + {{M_W{1'b0}}, round_up};
  // The hidden bit of the rounded significand is implicit in the packing.
  assign unused_hidden = m_sum[M_W-1];

  // A carry out of rounding leaves 1.000..0, i.e. an empty fraction and a
  // bumped exponent.
  always_comb begin
    if (m_sum[M_W]) begin
      frac_rnd = '0;
      e_rnd    = s2_e_q + E_ONE;
    end else begin
      frac_rnd = m_sum[FRAC_W-1:0];
      e_rnd    = s2_e_q;
    end
  end

  always_comb begin
    res      = ZERO;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_zero = 1'b0;
    if (s2_zero_q) begin
      res_zero = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      res.sign = s2_sign_q;
      res_unf  = 1'b1;
    end else if (e_rnd >= E_MAX_S) begin
      res      = INF;
      res.sign = s2_sign_q;
      res_ovf  = 1'b1;
    end else begin
      res.sign = s2_sign_q;
      res.exp  = e_rnd[EXP_W-1:0];
      res.frac = frac_rnd;
    end
  end

  // Result registers only load on a real beat so a stalled or idle output
  // keeps its last value.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    out_zero_d  = out_zero_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_data_d = res;
        out_ovf_d  = res_ovf;
        out_unf_d  = res_unf;
        out_zero_d = res_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sig_q    <= '0;
      s1_grs_q    <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_lz_q     <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_n_q      <= '0;
      s2_e_q      <= '0;
      s2_zero_q   <= 1'b0;
      s2_sign_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sig_q    <= s1_sig_d;
      s1_grs_q    <= s1_grs_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s1_lz_q     <= s1_lz_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s2_valid_d;
      s2_n_q      <= s2_n_d;
      s2_e_q      <= s2_e_d;
      s2_zero_q   <= s2_zero_d;
      s2_sign_q   <= s2_sign_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_norm_round_pack.sv
// tb_norm_round_pack: randomized + directed bench for norm_round_pack with
// an arithmetic reference model and an in-order scoreboard.
module tb_norm_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [24:0] sig_in;
  logic [2:0]  grs_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_ovf, out_unf, out_zero;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        ovf;
    logic        unf;
    logic        zero;
    logic [31:0] data;
  } res_t;

  res_t exp_q[$];
  res_t held;
  res_t want_pop;
  bit   hold_v = 0;
  int   txn = 0;

  always #5 clk = ~clk;

  norm_round_pack #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sig_in    (sig_in),
    .grs_in    (grs_in),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_zero  (out_zero)
  );

  // Reference: value arithmetic on integers, rounding decided from the
  // dropped bits, then the range classification.
  function automatic res_t model(logic [24:0] sig, logic [2:0] grs, logic [7:0] ex, logic sgn);
    res_t   r;
    longint m, w;
    int     e, lz;
    bit     g, rest;
    r = '0;
    if (sig == 0 && grs == 0) begin
      r.zero = 1'b1;
      return r;
    end
    if (sig[24]) begin
      m    = longint'(sig) / 2;
      g    = sig[0];
      rest = (grs != 0);
      e    = int'(ex) + 1;
    end else begin
      lz = 0;
      while (lz < 24 && sig[23-lz] == 1'b0) lz++;
      w    = ((longint'(sig[23:0]) * 8 + longint'(grs)) * (longint'(1) << lz)) % (longint'(1) << 27);
      m    = w / 8;
      g    = ((w / 4) % 2) == 1;
      rest = (w % 4) != 0;
      e    = int'(ex) - lz;
    end
    if (g && (rest || (m % 2) == 1)) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = longint'(1) << 23;
      e = e + 1;
    end
    if (e <= 0) begin
      r.unf  = 1'b1;
      r.data = {sgn, 31'h0};
    end else if (e >= 255) begin
      r.ovf  = 1'b1;
      r.data = {sgn, 8'hFF, 23'h0};
    end else begin
      r.data = {sgn, 8'(e), 23'(m)};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard / compare process.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'({out_ovf, out_unf, out_zero, out_data}), 64'(held));
      end
      if (out_valid) begin
        chk("flags_exclusive", 64'($countones({out_ovf, out_unf, out_zero}) <= 1), 64'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h required no output", out_data);
        end else begin
          want_pop = exp_q.pop_front();
          chk("result", 64'({out_ovf, out_unf, out_zero, out_data}), 64'(want_pop));
          $display("txn %0d data=%h ovf=%b unf=%b zero=%b", txn, out_data, out_ovf, out_unf, out_zero);
          txn++;
        end
      end
      hold_v = out_valid && !out_ready;
      held   = {out_ovf, out_unf, out_zero, out_data};
      if (in_valid && in_ready) exp_q.push_back(model(sig_in, grs_in, exp_in, sign_in));
    end
  end

  // Present one beat until accepted; returns 1 time unit after the capture edge.
  task automatic put(input logic [24:0] s, input logic [2:0] g, input logic [7:0] e, input logic sg);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    sig_in   = s;
    grs_in   = g;
    exp_in   = e;
    sign_in  = sg;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    chk("put_accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [24:0] s, input logic [2:0] g,
                          input logic [7:0] e, input logic sg, input logic [31:0] d,
                          input logic ovf, input logic unf, input logic zero);
    res_t want;
    int   lat;
    want = {ovf, unf, zero, d};
    chk({name, "_model"}, 64'(model(s, g, e, sg)), 64'(want));
    out_ready = 1'b1;
    put(s, g, e, sg);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(2));
    chk({name, "_out"}, 64'({out_ovf, out_unf, out_zero, out_data}), 64'(want));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n_out;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sig_in    = '0;
    grs_in    = '0;
    exp_in    = '0;
    sign_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({out_valid, out_ovf, out_unf, out_zero, out_data}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    directed("one",       25'h0800000, 3'b000, 8'd127, 1'b0, 32'h3F80_0000, 0, 0, 0);
    directed("carry",     25'h1000000, 3'b000, 8'd127, 1'b0, 32'h4000_0000, 0, 0, 0);
    directed("lshift1",   25'h0400000, 3'b000, 8'd127, 1'b0, 32'h3F00_0000, 0, 0, 0);
    directed("tie_odd",   25'h0800001, 3'b100, 8'd127, 1'b0, 32'h3F80_0002, 0, 0, 0);
    directed("tie_even",  25'h0800000, 3'b100, 8'd127, 1'b0, 32'h3F80_0000, 0, 0, 0);
    directed("mant_carry",25'h0FFFFFF, 3'b110, 8'd127, 1'b0, 32'h4000_0000, 0, 0, 0);
    directed("neg_one",   25'h0800000, 3'b011, 8'd127, 1'b1, 32'hBF80_0000, 0, 0, 0);
    directed("unf",       25'h0000001, 3'b000, 8'd10,  1'b0, 32'h0000_0000, 0, 1, 0);
    directed("unf_neg",   25'h0000001, 3'b000, 8'd10,  1'b1, 32'h8000_0000, 0, 1, 0);
    directed("exp0",      25'h0800000, 3'b000, 8'd0,   1'b0, 32'h0000_0000, 0, 1, 0);
    directed("exp255",    25'h0800000, 3'b000, 8'd255, 1'b1, 32'hFF80_0000, 1, 0, 0);
    directed("zero",      25'h0000000, 3'b000, 8'd50,  1'b1, 32'h0000_0000, 0, 0, 1);
    directed("ovf",       25'h1FFFFFF, 3'b000, 8'd254, 1'b0, 32'h7F80_0000, 1, 0, 0);

    // Reset with two beats in flight; the held ovf result must be cleared.
    out_ready = 1'b1;
    put(25'h0800000, 3'b000, 8'd127, 1'b0);
    put(25'h0400000, 3'b000, 8'd127, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 64'({out_valid, out_ovf, out_unf, out_zero, out_data}), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_dropped", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Backpressure: three back-to-back beats, output stalled four cycles.
    out_ready = 1'b0;
    put(25'h0800000, 3'b000, 8'd127, 1'b0);
    put(25'h1000000, 3'b000, 8'd127, 1'b0);
    put(25'h0400000, 3'b000, 8'd127, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_data", 64'(out_data), 64'(32'h3F80_0000));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n_out = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) n_out++;
    end
    chk("bp_count", 64'(n_out), 64'(3));
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 4) != 0;
      case ($urandom % 5)
        0: sig_in = 25'($urandom);
        1: sig_in = 25'($urandom) >> $urandom_range(0, 25);
        2: sig_in = 25'h1FFFFFF - 25'($urandom_range(0, 3));
        3: sig_in = 25'($urandom_range(0, 3));
        default: sig_in = {2'b01, 23'($urandom)};
      endcase
      grs_in  = 3'($urandom);
      sign_in = 1'($urandom);
      case ($urandom % 4)
        0: exp_in = 8'($urandom_range(0, 25));
        1: exp_in = 8'($urandom_range(250, 255));
        default: exp_in = 8'($urandom);
      endcase
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
